pc_fetch_ctrl: RTL
==================

// Module: pc_fetch_ctrl
// PURPOSE
// - Parametrised next-generation PC generator for the fetch stage; drives instruction address and chip-enable to instruction memory.
// - Adds a valid/ready fetch handshake, pipeline stall and branch redirect, plus a one-entry pending-redirect buffer for redirects that cannot apply immediately.
// - Sits between pipeline control (stall/branch from ctrl and ex) and the instruction ROM/bus.
// PARAMETERS
// - ADDR_W      32            PC width in bits
// - INST_BYTES  4             bytes per instruction; sequential increment; power of 2
// - RESET_VEC   32'h00000000  first fetch address after reset, ADDR_W wide
// - EXC_VEC     32'h00000020  flush target when exc_pc_i is unused (PC_EXC_EN builds only)
// PORTS
// - clk              in   1       clock, all state on posedge
// - rst              in   1       synchronous reset, active-low
// - stall_i          in   1       1 = hold PC (pipeline stall)
// - branch_i         in   1       1 = redirect to branch_target_i
// - branch_target_i  in   ADDR_W  redirect address
// - ready_i          in   1       memory accepted pc_o this cycle
// - pc_o             out  ADDR_W  current fetch address
// - ce_o             out  1       fetch request valid (chip enable)
// - pend_o           out  1       redirect buffered, not yet applied
// - flush_i          in   1       exception flush (PC_EXC_EN only)
// - exc_pc_i         in   ADDR_W  flush target; 0 selects EXC_VEC (PC_EXC_EN only)
// BEHAVIOUR
// - Reset (rst==0 at posedge): pc_o=RESET_VEC, ce_o=0, pend_o=0, pending address=0, state=IDLE.
// - States: IDLE (ce_o=0) -> RUN, one cycle after rst deasserts; RUN -> IDLE only via reset. Reset mid-fetch drops pending redirect.
// - First request presents RESET_VEC with ce_o=1; the first fetched address is never skipped.
// - Handshake: while ce_o=1 and ready_i=0, pc_o holds stable; a redirect cannot change it.
// - upd = RUN & ~stall_i & ready_i. Next PC priority on upd: branch_i target > pending address > pc_o+INST_BYTES.
// - Redirect applies at the posedge where upd=1, so pc_o shows the target one cycle later.
// - branch_i with upd=0 (stall, or not ready): target latched into pending, pend_o=1 next cycle; a later branch_i overwrites pending.
// - branch_i with upd=1: branch target used; any pending entry cleared (branch is youngest).
// - Pending consumed on first upd cycle; pend_o=0 on the following cycle.
// - stall_i with ready_i=1: memory refetches same pc_o; PC does not advance.
// - Arithmetic: increment modulo 2^ADDR_W (wrap all-ones-minus-step -> 0, no flag). Targets have low log2(INST_BYTES) bits forced to 0.
// - Latency: upd -> new pc_o after one clock; no combinational path from inputs to outputs.
// CONFIGURATION
// - Macro PC_EXC_EN. Defined: flush_i/exc_pc_i ports exist; flush_i=1 in RUN overrides stall_i, ready_i, branch_i and pending.
//   On flush, the next pc_o is exc_pc_i (EXC_VEC if exc_pc_i==0), pending is cleared and ce_o stays 1.
// - Not defined: flush_i/exc_pc_i ports, EXC_VEC logic and flush priority are absent; behaviour otherwise identical.
// STRUCTURE
// - Shared package cpu_pkg: state encoding (IDLE/RUN), ChipEnable/ChipDisable, RstEnable(=1'b0) and default ADDR_W/INST_BYTES constants.
// - Sub-module pc_redirect_buf: one-entry pending-address register with load/consume/clear; instantiated once. Top holds FSM, priority mux and PC register.
// TESTING
// - Reset hold 3 cycles, release, ready_i=1 -> pc_o 0,0(ce_o=1),4,8,0xC; ce_o 0 until first post-reset edge.
// - ready_i=0 for 4 cycles at pc 0x10 while branch_i pulses target 0x100 -> pc_o stays 0x10, pend_o=1; on ready_i=1, next pc_o=0x100, pend_o=0.
// - stall_i=1 with branch 0x40 then branch 0x80 -> pending=0x80; stall release -> pc_o=0x80 (last wins).
// - Branch with upd=1 while pending=0x200 -> branch target wins, pend_o clears.
// - pc_o=0xFFFFFFFC, ready_i=1 -> next pc_o=0x0; branch target 0x103 -> pc_o=0x100.
// - PC_EXC_EN: flush_i with stall_i=1, ready_i=0, pending set, exc_pc_i=0 -> pc_o=EXC_VEC, pend_o=0; rst mid-stall -> pc_o=RESET_VEC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, chip-enable and reset
// polarity constants, and default PC geometry.
package cpu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;
  localparam logic RstEnable   = 1'b0;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_INST_BYTES = 4;

endpackage : cpu_pkg

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch bus between the PC generator (master) and instruction memory (slave):
// address, chip-enable request and the memory's accept strobe.
interface pc_fetch_ctrl_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic [ADDR_W-1:0] pc_o;
  logic              ce_o;
  logic              ready_i;

  modport master (
    output pc_o,
    output ce_o,
    input  ready_i
  );

  modport slave (
    input  pc_o,
    input  ce_o,
    output ready_i
  );

endinterface : pc_fetch_ctrl_if

// File: rtl/pc_redirect_buf.sv
// One-entry pending-redirect register: holds a branch target that arrived while
// the PC could not advance, until the next accepted fetch consumes it.
module pc_redirect_buf
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_consume,
  input  logic              i_clear,
  output logic              o_pend,
  output logic [ADDR_W-1:0] o_addr
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;

  // Consume/clear win over load: a flush or an applied redirect makes any
  // simultaneous buffered target stale.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
    end else if (i_clear || i_consume) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_addr  <= i_addr;
    end
  end

  assign o_pend = r_valid;
  assign o_addr = r_addr;

endmodule : pc_redirect_buf

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC generator with valid/ready handshake, stall, branch redirect and
// a one-entry pending redirect. Optional exception flush when PC_EXC_EN is defined.
module pc_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter int                INST_BYTES = DEF_INST_BYTES,
`ifdef PC_EXC_EN
  parameter logic [ADDR_W-1:0] EXC_VEC    = ADDR_W'(32'h0000_0020),
`endif
  parameter logic [ADDR_W-1:0] RESET_VEC  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_target_i,
`ifdef PC_EXC_EN
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] exc_pc_i,
`endif
  output logic              pend_o,
  pc_fetch_ctrl_if.master   bus
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(INST_BYTES - 1));
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(INST_BYTES);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_target;
  logic              w_upd;
  logic              w_buf_load;
  logic              w_buf_consume;
  logic              w_buf_clear;
  logic              w_buf_pend;
  logic [ADDR_W-1:0] w_buf_addr;

  assign w_target = branch_target_i & ALIGN_MASK;
  assign w_upd    = (r_state == RUN) && !stall_i && bus.ready_i;

  pc_redirect_buf #(
    .ADDR_W (ADDR_W)
  ) u_redirect_buf (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_buf_load),
    .i_addr    (w_target),
    .i_consume (w_buf_consume),
    .i_clear   (w_buf_clear),
    .o_pend    (w_buf_pend),
    .o_addr    (w_buf_addr)
  );

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst == RstEnable) begin
      r_state <= IDLE;
      r_pc    <= RESET_VEC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_buf_load    = 1'b0;
    w_buf_consume = 1'b0;
    w_buf_clear   = 1'b0;
    case (r_state)
      IDLE: w_state_nxt = RUN;
      RUN: begin
`ifdef PC_EXC_EN
        if (flush_i) begin
          w_pc_nxt    = ((exc_pc_i == '0) ? EXC_VEC : exc_pc_i) & ALIGN_MASK;
          w_buf_clear = 1'b1;
        end else
`endif
        if (w_upd) begin
          // Branch is the youngest redirect, so it beats a buffered one.
          if (branch_i)        w_pc_nxt = w_target;
          else if (w_buf_pend) w_pc_nxt = w_buf_addr;
          else                 w_pc_nxt = r_pc + PC_STEP;
          w_buf_consume = 1'b1;
        end else if (branch_i) begin
          w_buf_load = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.pc_o = r_pc;
  assign bus.ce_o = (r_state == RUN) ? ChipEnable : ChipDisable;
  assign pend_o   = w_buf_pend;

  // An outstanding request must keep its address until memory accepts it.
`ifdef PC_EXC_EN
  a_hold_addr : assert property (@(posedge clk) disable iff (rst == RstEnable)
    (bus.ce_o && !bus.ready_i && !flush_i) |=> $stable(bus.pc_o));
`else
  a_hold_addr : assert property (@(posedge clk) disable iff (rst == RstEnable)
    (bus.ce_o && !bus.ready_i) |=> $stable(bus.pc_o));
`endif

endmodule : pc_fetch_ctrl
